// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks (adder and subtractor side).
// Holds the common FSM state type and the default datapath width.
package arith_pkg;

  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arith_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the mirror of the full subtractor cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell and a carry flop, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder
  import arith_pkg::*;
#(
  parameter  int N  = ARITH_W,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
);

  arith_state_e  state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cell_sum, cell_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {cell_sum, res_q[N-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + CW'(1);
        // Result registers load only on the last bit so they hold through IDLE/RUN.
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = {cell_sum, res_q[N-1:1]};
          cout_d  = cell_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, handshake corner
// cases, an exhaustive N=3 sweep and random operands against a+b+cin.
module tb_serial_adder;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a, b, sum;
  logic       cin, cout;

  logic       in_valid3, in_ready3, out_valid3, busy3;
  logic [2:0] a3, b3, sum3;
  logic       cin3, cout3;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .cin(cin3), .out_valid(out_valid3), .out_ready(1'b1),
    .sum(sum3), .cout(cout3), .busy(busy3)
  );

  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_cin, input logic [7:0] exp_sum, input logic exp_cout,
                        input bit scramble);
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    a = op_a; b = op_b; cin = op_cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_idle_ready"}, {in_ready, out_valid}, 2'b10);
    end
  endtask

  task automatic run_op3(input logic [2:0] op_a, input logic [2:0] op_b, input logic op_cin);
    int   cyc;
    int   total;
    total = int'(op_a) + int'(op_b) + int'(op_cin);
    a3 = op_a; b3 = op_b; cin3 = op_cin; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    cyc = 0;
    while (out_valid3 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("n3_result", {cyc[7:0], cout3, sum3}, {8'd3, 1'(total >> 3), 3'(total)});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[6];
    logic [8:0] r;
    logic [7:0] ra, rb;
    logic       rc;

    vecs[0] = '{"plus_0f_01",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{"wrap_ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{"max_ff_ff_c",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{"zero",         8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{"msb_carry",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{"cin_ripple",   8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    #12;
    check("reset_outputs", {in_ready, out_valid, busy, cout, sum}, {4'b1000, 8'h00});
    check("reset_n3", {in_ready3, out_valid3, busy3, cout3, sum3}, {4'b1000, 3'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, 1'b0);

    // Inverse of the 1-bit full subtractor: diff + b + borrow_in gives back the minuend bit.
    for (int i = 0; i < 8; i++) begin
      logic m, s, bin, diff;
      m = i[2]; s = i[1]; bin = i[0];
      diff = m ^ s ^ bin;
      r = ref_add({7'd0, diff}, {7'd0, s}, bin);
      run_op("inverse", {7'd0, diff}, {7'd0, s}, bin, r[7:0], r[8], 1'b0);
      check("inverse_minuend", sum[0], m);
    end

    // Backpressure: result held, second request ignored.
    out_ready = 1'b0;
    run_op("bp", 8'h3C, 8'h21, 1'b0, 8'h5D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, busy, cout, sum}, {4'b1000, 8'h5D});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {out_valid, in_ready, busy, sum}, {3'b010, 8'h5D});
    @(posedge clk); #1;
    check("bp_no_accept", {busy, in_ready}, 2'b01);

    // Asynchronous reset while bit 4 is being processed.
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_run_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_run_reset", {out_valid, busy, in_ready, cout, sum}, {4'b0010, 8'h00});
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    run_op("scramble", 8'h5A, 8'h3B, 1'b1, 8'h96, 1'b0, 1'b1);

    for (int av = 0; av < 8; av++)
      for (int bv = 0; bv < 8; bv++)
        for (int cv = 0; cv < 2; cv++)
          run_op3(3'(av), 3'(bv), 1'(cv));

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r = ref_add(ra, rb, rc);
      run_op("random", ra, rb, rc, r[7:0], r[8], 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
